fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side consumer for the team's synchronous FIFO. It drains the FIFO read port, absorbs the FIFO's one-cycle registered read latency, and presents words downstream on a valid/ready stream. It never causes FIFO underflow, sustains one word per cycle when the sink is always ready, and flags underflow pulses caused by any other read master.

## Interface
- FIFO_WIDTH, 16: data width; must equal the FIFO's FIFO_WIDTH.
- CNT_WIDTH, 16: width of the read counter.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new FIFO reads when high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after a read was accepted.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_rd_en  out  1  FIFO read enable (combinational).
- m_data  out  FIFO_WIDTH  stream data (head of the skid buffer).
- m_valid  out  1  stream valid.
- m_ready  in  1  sink ready.
- rd_count  out  CNT_WIDTH  number of FIFO reads issued; wraps modulo 2^CNT_WIDTH.
- clr_err  in  1  clears err_underflow.
- err_underflow  out  1  sticky underflow error.

## Operation
- State:
  - 2-entry skid buffer with 1-bit head and tail pointers that wrap 1→0.
  - buf_count, range 0..2.
  - inflight: fifo_rd_en registered.
- pop = m_valid && m_ready. m_valid = (buf_count != 0). m_data = mem[head].
- fifo_rd_en = enable && !fifo_empty && (buf_count + inflight − pop < 2). This guarantees buffer space for the word returning next cycle. No read is issued while fifo_empty = 1, so the reader never triggers underflow.
- Capture: at each edge with inflight = 1, write fifo_data_out to mem[tail] and advance tail.
- Simultaneous capture and pop: buf_count is unchanged, and both pointers advance.
- Next-state update: buf_count_next = buf_count + inflight − pop. It never exceeds 2. Overflow of the skid buffer is an assertion failure.
- Stream rule: while m_valid && !m_ready, m_data and m_valid hold stable. Words leave in strict FIFO order, with no loss and no duplication.
- enable low: no new fifo_rd_en. A word already in flight is still captured, and the buffer keeps draining to the sink.
- rd_count increments at each edge where fifo_rd_en = 1.
- err_underflow is set at any edge where fifo_underflow = 1. It clears on clr_err. If set and clear occur in the same cycle, set wins.
- Reset values, applied asynchronously and immediately:
  - m_valid = 0, m_data = 0, err_underflow = 0, rd_count = 0.
  - buf_count = 0, inflight = 0, head = tail = 0.
  - fifo_rd_en = 0 while rst_n = 0.
  - Any in-flight word is discarded.

## Timing
- FIFO contract: fifo_rd_en sampled high at edge E with the FIFO non-empty → fifo_data_out carries the word during the cycle after E → the reader captures it at edge E+1.
- Latency: first fifo_rd_en with the sink idle → m_valid high 2 cycles later (after edge E+1). fifo_empty falling → m_valid rising takes 2 cycles.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is buf_count = 1, inflight = 1, one read and one pop per cycle.
- Backpressure: with m_ready low, at most 2 reads are outstanding or buffered. fifo_rd_en drops in the cycle where buf_count + inflight = 2. On m_ready rising, fifo_rd_en reasserts in that same cycle (combinational path from m_ready).
- FIFO last word: with FIFO count = 1, one read is issued, fifo_empty rises next cycle, and no further read is issued.

## Test plan
- Preload FIFO with 0x0001–0x0008, enable = 1, m_ready = 1:
  - fifo_rd_en high for 8 consecutive cycles, then low.
  - m_valid high for 8 consecutive cycles starting 2 cycles after the first read.
  - Data 0x0001..0x0008 in order, rd_count = 8, err_underflow = 0.
- FIFO holds 0x0011–0x0015, m_ready = 0:
  - Exactly 2 reads issued, fifo_rd_en then stays low, m_data holds 0x0011 stable.
  - m_ready → 1: 0x0011..0x0015 delivered in order, rd_count = 5.
- m_ready toggling 1,0,1,0 against FIFO data 0x00A0–0x00A7 → all 8 words delivered in order, each exactly once, and buf_count never exceeds 2.
- enable dropped one cycle after a read is issued → the in-flight word is still captured and delivered, and no further fifo_rd_en appears until enable returns.
- Empty FIFO, enable = 1 → fifo_rd_en never asserted. Force fifo_underflow = 1 for one cycle → err_underflow = 1 and held. Assert clr_err together with fifo_underflow = 1 → stays 1. Assert clr_err alone → 0.
- Assert rst_n = 0 mid-stream with the buffer full and a read in flight → all outputs reach reset values without waiting for a clock edge. After release with a refilled FIFO → no stale word is emitted, and rd_count restarts from 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: absorbs the one-cycle read latency
// through a 2-entry skid buffer and presents words on a valid/ready stream.
`timescale 1ns/1ps

module fifo_stream_reader_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] buf_count,
    input  logic       inflight
);
    // Buffered plus in-flight words must always fit in the two skid entries.
    property p_no_overflow;
        @(posedge clk) disable iff (!rst_n)
            ({1'b0, buf_count} + {2'b00, inflight}) <= 3'd2;
    endproperty
    a_no_overflow: assert property (p_no_overflow);
endmodule

module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    input  logic                  clr_err,
    output logic                  err_underflow
);
    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic [FIFO_WIDTH-1:0] mem_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic                  err_q, err_d;
    logic                  pop_s;

    assign m_valid       = (buf_count_q != 2'd0);
    assign m_data        = mem_q[head_q];
    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;

    // Next-state and FIFO read-enable: a read is issued only if its word will have a slot next cycle.
    always_comb begin
        pop_s       = m_valid && m_ready;
        buf_count_d = buf_count_q + {1'b0, inflight_q} - {1'b0, pop_s};
        fifo_rd_en  = rst_n && enable && !fifo_empty && (buf_count_d < 2'd2);
        inflight_d  = fifo_rd_en;
        mem_d       = mem_q;

        if (inflight_q) begin
            mem_d[tail_q] = fifo_data_out;
            tail_d        = tail_q + 1'b1;
        end else begin
            tail_d        = tail_q;
        end

        if (pop_s) begin
            head_d = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end

        if (fifo_rd_en) begin
            rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_count_d = rd_count_q;
        end

        // A new underflow outranks a simultaneous clear.
        if (fifo_underflow) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset drops any word still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]    <= {FIFO_WIDTH{1'b0}};
            mem_q[1]    <= {FIFO_WIDTH{1'b0}};
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            buf_count_q <= 2'd0;
            inflight_q  <= 1'b0;
            rd_count_q  <= {CNT_WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            head_q      <= head_d;
            tail_q      <= tail_d;
            buf_count_q <= buf_count_d;
            inflight_q  <= inflight_d;
            rd_count_q  <= rd_count_d;
            err_q       <= err_d;
        end
    end

    fifo_stream_reader_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .buf_count (buf_count_q),
        .inflight  (inflight_q)
    );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-level stream model checked every cycle,
// plus hand-computed expectations taken from the directed scenarios.
`timescale 1ns/1ps

module tb_fifo_stream_reader;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] rd_count;
    logic        clr_err;
    logic        err_underflow;

    fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .clr_err        (clr_err),
        .err_underflow  (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench-side FIFO with one-cycle registered read data.
    logic [15:0] fmem [0:255];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    int          rd_bad;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= wr_ptr;
            fifo_data_out <= 16'h0000;
        end else if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                rd_bad <= rd_bad + 1;
            end else begin
                fifo_data_out <= fmem[rd_ptr];
                rd_ptr        <= rd_ptr + 8'd1;
            end
        end
    end

    int          n_vec;
    int          n_err;
    logic [15:0] buf_m [$];
    logic [15:0] got_q [$];
    logic        fly;
    logic [15:0] fly_w;
    logic [7:0]  mrd;
    int          mcnt;
    logic        merr;
    logic        last_rd;
    logic        last_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: the stream carries exactly the FIFO words in read order; a read lands one edge later.
    task automatic check_cycle();
        logic exp_v;
        logic pop;
        logic exp_rd;
        int   occ;
        last_rd  = fifo_rd_en;
        last_val = m_valid;
        if (!rst_n) begin
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_m_data", {16'd0, m_data}, 32'd0);
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rst_rd_count", {16'd0, rd_count}, 32'd0);
            check("rst_err", {31'd0, err_underflow}, 32'd0);
            buf_m.delete();
            fly  = 1'b0;
            mcnt = 0;
            merr = 1'b0;
            mrd  = wr_ptr;
        end else begin
            exp_v = (buf_m.size() != 0);
            check("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
            if (exp_v) check("m_data", {16'd0, m_data}, {16'd0, buf_m[0]});
            pop    = exp_v && m_ready;
            occ    = buf_m.size() + (fly ? 1 : 0) - (pop ? 1 : 0);
            exp_rd = enable && (mrd != wr_ptr) && (occ < 2);
            check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
            check("rd_count", {16'd0, rd_count}, {16'd0, mcnt[15:0]});
            check("err_underflow", {31'd0, err_underflow}, {31'd0, merr});
            if (pop) begin
                got_q.push_back(m_data);
                void'(buf_m.pop_front());
            end
            if (fly) buf_m.push_back(fly_w);
            fly = exp_rd;
            if (exp_rd) begin
                fly_w = fmem[mrd];
                mrd   = mrd + 8'd1;
                mcnt++;
            end
            if (fifo_underflow) merr = 1'b1;
            else if (clr_err)   merr = 1'b0;
        end
    endtask

    task automatic step();
        #4;
        check_cycle();
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
    endtask

    task automatic check_got(input string name, input int base, input int n, input logic [15:0] first);
        check({name, "_count"}, got_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < got_q.size())
                check({name, "_word"}, {16'd0, got_q[base + i]}, {16'd0, first + 16'(i)});
        end
    endtask

    initial begin
        logic [13:0] rd_hist;
        logic [13:0] val_hist;
        int          base;
        n_vec = 0;
        n_err = 0;
        rd_bad = 0;
        wr_ptr = 8'd0;
        enable = 1'b0;
        m_ready = 1'b0;
        fifo_underflow = 1'b0;
        clr_err = 1'b0;
        rst_n = 1'b0;
        fly = 1'b0;
        fly_w = 16'h0000;
        mrd = 8'd0;
        mcnt = 0;
        merr = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Full-rate drain of 0x0001..0x0008.
        base = got_q.size();
        for (int i = 1; i <= 8; i++) push(16'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            rd_hist[i]  = last_rd;
            val_hist[i] = last_val;
        end
        check("t1_rd_pattern", {18'd0, rd_hist}, 32'h0000_00FF);
        check("t1_valid_pattern", {18'd0, val_hist}, 32'h0000_03FC);
        check("t1_rd_count", {16'd0, rd_count}, 32'd8);
        check("t1_err", {31'd0, err_underflow}, 32'd0);
        check_got("t1", base, 8, 16'h0001);

        // Backpressure: only two reads while the sink stalls.
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 5; i++) push(16'h0011 + 16'(i));
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            rd_hist[i] = last_rd;
        end
        check("t2_rd_pattern", {26'd0, rd_hist[5:0]}, 32'h0000_0003);
        check("t2_stall_data", {16'd0, m_data}, 32'h0000_0011);
        check("t2_stall_valid", {31'd0, m_valid}, 32'd1);
        check("t2_stall_rd_count", {16'd0, rd_count}, 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t2_rd_count", {16'd0, rd_count}, 32'd5);
        check_got("t2", base, 5, 16'h0011);

        // Toggling sink ready.
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        check_got("t3", base, 8, 16'h00A0);

        // Enable dropped right after one read.
        do_reset();
        m_ready = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 3; i++) push(16'h0061 + 16'(i));
        step();
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t4_rd_count_hold", {16'd0, rd_count}, 32'd1);
        check_got("t4a", base, 1, 16'h0061);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t4_rd_count", {16'd0, rd_count}, 32'd3);
        check_got("t4b", base, 3, 16'h0061);

        // Empty FIFO and sticky error.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t5_rd_count", {16'd0, rd_count}, 32'd0);
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        check("t5_err_set", {31'd0, err_underflow}, 32'd1);
        step();
        check("t5_err_hold", {31'd0, err_underflow}, 32'd1);
        clr_err = 1'b1;
        fifo_underflow = 1'b1;
        step();
        clr_err = 1'b0;
        fifo_underflow = 1'b0;
        check("t5_set_wins", {31'd0, err_underflow}, 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t5_err_clr", {31'd0, err_underflow}, 32'd0);

        // Asynchronous reset mid-stream with a word in flight.
        do_reset();
        for (int i = 0; i < 6; i++) push(16'h0041 + 16'(i));
        enable = 1'b1;
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, m_valid}, 32'd0);
        check("t6_async_data", {16'd0, m_data}, 32'd0);
        check("t6_async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("t6_async_count", {16'd0, rd_count}, 32'd0);
        check("t6_async_err", {31'd0, err_underflow}, 32'd0);
        #1;
        check_cycle();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        m_ready = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 3; i++) push(16'h0051 + 16'(i));
        for (int i = 0; i < 8; i++) step();
        check("t6_rd_count", {16'd0, rd_count}, 32'd3);
        check_got("t6", base, 3, 16'h0051);

        check("no_reader_underflow", rd_bad, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
